crc_mem_arbiter: RTL and testbench
==================================

Name: crc_mem_arbiter

Overview:
- Two-master arbiter sharing the single-port on-chip RAM (32-bit, byte-enabled, 1-cycle read latency, unregistered q) between the Nios II data master (m0) and the CRC accelerator's DMA master (m1).
- Sits between both Avalon-MM masters and the RAM slave port.
- Issues at most one RAM access per cycle, selected by round-robin.
- Returns read data with per-master readdatavalid.

Parameters:
- ADDR_W, 16, word address width of both masters and the RAM.
- HOLD_MAX, 4, maximum consecutive grants to one master under contention; only used with ARB_HOLD_EN; legal range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0_address  input  ADDR_W  master 0 word address.
- m0_byteenable  input  4  master 0 byte enables.
- m0_read  input  1  master 0 read request.
- m0_write  input  1  master 0 write request.
- m0_writedata  input  32  master 0 write data.
- m0_waitrequest  output  1  master 0 request not accepted this cycle.
- m0_readdata  output  32  master 0 read data.
- m0_readdatavalid  output  1  m0_readdata valid.
- m1_*  same set as m0_*  master 1 (CRC DMA).
- mem_address  output  ADDR_W  RAM address.
- mem_byteenable  output  4  RAM byte enables.
- mem_chipselect  output  1  RAM access this cycle.
- mem_write  output  1  RAM write strobe.
- mem_writedata  output  32  RAM write data.
- mem_clken  output  1  RAM clock enable; tied 1.
- mem_readdata  input  32  RAM read data, valid one cycle after the read address.

Behaviour:
- Request: reqN = mN_read | mN_write.
  - If read and write are both asserted, treat the request as a write; the read is ignored.
- Grant (combinational, single cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master that is not last_grant.
  - Neither requesting: no grant; mem_chipselect=0, mem_write=0.
- Datapath mux (combinational from the granted master): mem_address, mem_byteenable, mem_writedata, mem_write.
  - mem_chipselect=1 whenever any grant is made.
  - With no grant, mem_address, mem_byteenable and mem_writedata hold master 0 values.
- mN_waitrequest = reqN & ~grantN.
  - Deasserted when idle.
  - An accepted request completes in the cycle waitrequest is low.
- last_grant register: updates to the granted master on every accepted access. Reset value 1, so m0 wins the first tie.
- Read return:
  - rd_pend and rd_owner registers capture an accepted read.
  - mN_readdatavalid = rd_pend & (rd_owner==N), registered, exactly 1 cycle after acceptance.
  - Back-to-back reads from either or alternating masters are pipelined, one per cycle, no bubbles.
- m0_readdata = m1_readdata = mem_readdata, broadcast; qualify with readdatavalid.
- Writes: no response. Write data is committed by the RAM on the acceptance edge.
- Read-after-write to the same address in consecutive cycles returns the new data, per the RAM's single-port behaviour.
- Reset values: m0/m1_readdatavalid=0; rd_pend=0; rd_owner=0; last_grant=1; hold counter=0.
  - Combinational outputs follow from inputs.
  - Reset asserted mid-operation: an in-flight readdatavalid is dropped immediately (asynchronously) and never issued.
- Throughput: 100% RAM utilisation under continuous requests. Under sustained contention without ARB_HOLD_EN, grants alternate m0,m1,m0,...

Optional Feature:
- Macro: ARB_HOLD_EN.
- Defined:
  - An 8-bit hold counter tracks consecutive grants to the current owner.
  - Under contention, the owner keeps the grant while it continues requesting and count < HOLD_MAX.
  - When count reaches HOLD_MAX, the other master is granted and the counter restarts at 1.
  - The counter resets to 1 on any owner change and to 0 when the owner stops requesting.
  - With HOLD_MAX=1 the arbiter is identical to the undefined case.
- Undefined: no counter; pure alternate round-robin; HOLD_MAX ignored.

Test Plan:
- Reset, then m0 reads addr 0x0010 (RAM preloaded with 0xDEADBEEF) -> m0_waitrequest=0 in the request cycle; m0_readdatavalid=1 with 0xDEADBEEF exactly 1 cycle later; m1_readdatavalid stays 0.
- m0 and m1 both write continuously (m0: 0x100+i, m1: 0x200+i), macro undefined -> grants alternate starting with m0; each waitrequest is high every other cycle; all 8 locations read back correct.
- m1 writes 0x12345678 with byteenable=4'b0010 to addr 5 (prior value 0) -> subsequent read returns 0x00005600.
- Back-to-back alternating reads m0@1, m1@2, m0@3 -> readdatavalid pulses on m0, m1, m0 in consecutive cycles with the matching data; no idle cycles.
- Assert reset_n=0 in the cycle after an accepted m1 read -> m1_readdatavalid never asserts; after release, the first tie goes to m0.
- ARB_HOLD_EN, HOLD_MAX=4, both masters request continuously -> grant pattern m0×4, m1×4, m0×4; m0 dropping its request after 2 grants passes the grant to m1 immediately.

Source files
------------

// File: rtl/crc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crc_mem_arbiter
// Purpose  : Two-master round-robin arbiter that shares one single-port
//            on-chip RAM between the Nios II data master (m0) and the CRC
//            DMA master (m1). At most one RAM access is issued per cycle.
//            Read data is broadcast to both masters and qualified by a
//            per-master readdatavalid one cycle after acceptance.
// Options  : `define ARB_HOLD_EN lets the current owner keep the grant for up
//            to HOLD_MAX consecutive accesses under contention. Without it the
//            arbiter strictly alternates under contention.
// Ports    : clk, reset_n (async, active low)
//            m0_* / m1_*  : Avalon-MM master side (address, byteenable, read,
//                           write, writedata, waitrequest, readdata,
//                           readdatavalid)
//            mem_*        : RAM slave side (address, byteenable, chipselect,
//                           write, writedata, clken, readdata)
// Revision : 1.0  initial release
// ============================================================================
module crc_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("crc_mem_arbiter: HOLD_MAX must be in 1..255");
  end

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_acc_write;
  logic w_keep;          // owner retains the grant under contention
  logic r_last_grant;    // 0 = m0, 1 = m1
  logic r_rd_pend;
  logic r_rd_owner;

  // A simultaneous read+write counts as a single write request.
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

`ifdef ARB_HOLD_EN
  localparam logic [7:0] C_HOLD_MAX = 8'(HOLD_MAX);

  logic [7:0] r_hold_cnt;

  // A zero count means the previous owner stopped requesting, so the next
  // tie falls back to plain alternation.
  assign w_keep = (r_hold_cnt != 8'd0) && (r_hold_cnt < C_HOLD_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= 8'd0;
    end else if (!w_gnt_any) begin
      r_hold_cnt <= 8'd0;
    end else if (w_gnt1 != r_last_grant) begin
      r_hold_cnt <= 8'd1;
    end else if (r_hold_cnt != 8'hFF) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && w_req1) begin
      if (w_keep) begin
        w_gnt0 = ~r_last_grant;
        w_gnt1 = r_last_grant;
      end else begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end
    end else begin
      w_gnt0 = w_req0;
      w_gnt1 = w_req1;
    end
  end

  assign w_gnt_any   = w_gnt0 | w_gnt1;
  assign w_acc_write = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);

  // Datapath defaults to master 0 when nothing is granted.
  assign mem_address    = w_gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign mem_write      = w_acc_write;
  assign mem_chipselect = w_gnt_any;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt_any & ~w_acc_write;
      if (w_gnt_any) begin
        r_last_grant <= w_gnt1;
        r_rd_owner   <= w_gnt1;
      end
    end
  end

  // RAM output is unregistered, so the returning word lines up with the
  // pending flag captured on the acceptance edge.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = r_rd_pend & r_rd_owner;

endmodule
`default_nettype wire

// File: tb/tb_crc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_mem_arbiter
// Purpose  : Self-checking bench for crc_mem_arbiter with a behavioural RAM,
//            a transaction-level reference model and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_crc_mem_arbiter;
  localparam int ADDR_W   = 16;
  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_on  = 1'b1;
  int gseq[$];

  always #5 clk = ~clk;

  crc_mem_arbiter #(.ADDR_W(ADDR_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // ---------------- behavioural single-port RAM ----------------
  bit [31:0]   ram [0:255];
  bit          ram_init = 1'b0;
  logic [31:0] ram_q = 32'h0;

  always @(posedge clk) begin
    if (!ram_init) begin
      ram[8'h10] <= 32'hDEADBEEF;
      ram_init   <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address[7:0]];
      end
    end
  end
  assign mem_readdata = ram_q;

  // ---------------- reference model ----------------
  bit [31:0]   mmem [0:255];
  bit          mm_init = 1'b0;
  int          m_last  = 1;
  int          m_cnt   = 0;
  bit          m_pend  = 1'b0;
  int          m_owner = 0;
  logic [31:0] m_data  = 32'h0;

  // Which master wins this cycle: -1 none, 0 or 1.
  function automatic int mgrant();
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (r0 && r1) begin
`ifdef ARB_HOLD_EN
      if (m_cnt > 0 && m_cnt < HOLD_MAX) return m_last;
`endif
      return 1 - m_last;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit wr_of(input int g);
    return (g == 0) ? m0_write : m1_write;
  endfunction

  function automatic logic [7:0] aidx(input int g);
    return (g == 0) ? m0_address[7:0] : m1_address[7:0];
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] old, input int g);
    logic [31:0] wd, r;
    logic [3:0]  be;
    wd = (g == 0) ? m0_writedata : m1_writedata;
    be = (g == 0) ? m0_byteenable : m1_byteenable;
    r  = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model_mem_p
    int g;
    g = mgrant();
    if (!mm_init) begin
      mmem[8'h10] <= 32'hDEADBEEF;
      mm_init     <= 1'b1;
    end else if (reset_n && g >= 0 && wr_of(g)) begin
      mmem[aidx(g)] <= merged(mmem[aidx(g)], g);
    end
  end

  always @(posedge clk or negedge reset_n) begin : model_ctl_p
    int g;
    if (!reset_n) begin
      m_last  <= 1;
      m_cnt   <= 0;
      m_pend  <= 1'b0;
      m_owner <= 0;
    end else begin
      g = mgrant();
      if (g < 0) begin
        m_cnt  <= 0;
        m_pend <= 1'b0;
      end else begin
        m_cnt   <= (g == m_last) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
        m_last  <= g;
        m_pend  <= !wr_of(g);
        m_owner <= g;
        m_data  <= mmem[aidx(g)];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'b0, act}, {31'b0, exp});
  endtask

  always @(negedge clk) begin : cmp_p
    int   g;
    logic e_v0, e_v1;
    if (cmp_on) begin
      g    = mgrant();
      e_v0 = m_pend && (m_owner == 0);
      e_v1 = m_pend && (m_owner == 1);
      chk1("mem_chipselect", mem_chipselect, g >= 0);
      chk1("mem_write", mem_write, (g >= 0) ? wr_of(g) : 1'b0);
      chk32("mem_address", {16'b0, mem_address}, {16'b0, (g == 1) ? m1_address : m0_address});
      chk32("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, (g == 1) ? m1_byteenable : m0_byteenable});
      chk32("mem_writedata", mem_writedata, (g == 1) ? m1_writedata : m0_writedata);
      chk1("mem_clken", mem_clken, 1'b1);
      chk1("m0_waitrequest", m0_waitrequest, (m0_read | m0_write) && g != 0);
      chk1("m1_waitrequest", m1_waitrequest, (m1_read | m1_write) && g != 1);
      chk1("m0_readdatavalid", m0_readdatavalid, e_v0);
      chk1("m1_readdatavalid", m1_readdatavalid, e_v1);
      if (e_v0) chk32("m0_readdata", m0_readdata, m_data);
      if (e_v1) chk32("m1_readdata", m1_readdata, m_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontended access; starts and ends 1 time unit after a rising edge.
  task automatic single(input int m, input bit wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = !wr; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = !wr; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
    @(negedge clk);
    chk1("single_accept", (m == 0) ? m0_waitrequest : m1_waitrequest, 1'b0);
    tick();
    clr();
  endtask

  task automatic read_chk(input int m, input logic [15:0] a, input logic [31:0] exp);
    single(m, 1'b0, a, 32'h0, 4'hF);
    @(negedge clk);
    chk1("rd_valid", (m == 0) ? m0_readdatavalid : m1_readdatavalid, 1'b1);
    chk1("rd_other_quiet", (m == 0) ? m1_readdatavalid : m0_readdatavalid, 1'b0);
    chk32("rd_data", (m == 0) ? m0_readdata : m1_readdata, exp);
    tick();
  endtask

  // Both masters hold requests until accepted; records grant order in gseq.
  task automatic contend(input bit wr, input int n0, input int n1);
    int  i0, i1, cyc;
    bit  a0, a1;
    i0 = 0; i1 = 0; cyc = 0;
    gseq.delete();
    while ((i0 < n0 || i1 < n1) && cyc < 40) begin
      m0_read  = !wr && (i0 < n0); m0_write = wr && (i0 < n0);
      m0_address = 16'(32'h20 + i0); m0_writedata = 32'h100 + i0; m0_byteenable = 4'hF;
      m1_read  = !wr && (i1 < n1); m1_write = wr && (i1 < n1);
      m1_address = 16'(32'h30 + i1); m1_writedata = 32'h200 + i1; m1_byteenable = 4'hF;
      @(negedge clk);
      a0 = (i0 < n0) && !m0_waitrequest;
      a1 = (i1 < n1) && !m1_waitrequest;
      if (a0) gseq.push_back(0);
      if (a1) gseq.push_back(1);
      tick();
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    clr();
    if (cyc >= 40) chk1("contend_timeout", 1'b1, 1'b0);
  endtask

  task automatic chk_seq(input string nm, input string exp);
    chk32({nm, "_len"}, gseq.size(), exp.len());
    for (int i = 0; i < exp.len() && i < gseq.size(); i++)
      chk32(nm, gseq[i], 32'(exp[i] - 8'h30));
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    @(negedge clk);
    chk1("rst_m0_rdv", m0_readdatavalid, 1'b0);
    chk1("rst_m1_rdv", m1_readdatavalid, 1'b0);
    chk1("rst_cs", mem_chipselect, 1'b0);
    chk1("rst_m0_wait", m0_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // m0 reads the preloaded word
    single(0, 1'b0, 16'h0010, 32'h0, 4'hF);
    @(negedge clk);
    chk1("t1_m0_rdv", m0_readdatavalid, 1'b1);
    chk32("t1_data", m0_readdata, 32'hDEADBEEF);
    chk1("t1_m1_rdv", m1_readdatavalid, 1'b0);
    tick();

    // byte-lane write by m1
    single(1, 1'b1, 16'd5, 32'h12345678, 4'b0010);
    read_chk(1, 16'd5, 32'h00005600);

    // continuous write contention; last grant is m1 so m0 starts
    contend(1'b1, 4, 4);
`ifdef ARB_HOLD_EN
    chk_seq("t2_grants", "00001111");
`else
    chk_seq("t2_grants", "01010101");
`endif
    for (int i = 0; i < 4; i++) read_chk(0, 16'(32'h20 + i), 32'h100 + i);
    for (int i = 0; i < 4; i++) read_chk(1, 16'(32'h30 + i), 32'h200 + i);

    // back-to-back alternating reads
    single(0, 1'b1, 16'd1, 32'h0000_00A1, 4'hF);
    single(1, 1'b1, 16'd2, 32'h0000_00B2, 4'hF);
    single(0, 1'b1, 16'd3, 32'h0000_00C3, 4'hF);
    m0_read = 1; m0_address = 16'd1; m0_byteenable = 4'hF;
    @(negedge clk); chk1("t4_acc0", m0_waitrequest, 1'b0);
    tick(); clr();
    m1_read = 1; m1_address = 16'd2; m1_byteenable = 4'hF;
    @(negedge clk);
    chk1("t4_v0a", m0_readdatavalid, 1'b1); chk32("t4_d0a", m0_readdata, 32'hA1);
    chk1("t4_acc1", m1_waitrequest, 1'b0);
    tick(); clr();
    m0_read = 1; m0_address = 16'd3; m0_byteenable = 4'hF;
    @(negedge clk);
    chk1("t4_v1", m1_readdatavalid, 1'b1); chk32("t4_d1", m1_readdata, 32'hB2);
    chk1("t4_v0_gap", m0_readdatavalid, 1'b0);
    tick(); clr();
    @(negedge clk);
    chk1("t4_v0b", m0_readdatavalid, 1'b1); chk32("t4_d0b", m0_readdata, 32'hC3);
    tick();

    // read immediately after write to the same address
    single(0, 1'b1, 16'd7, 32'hCAFEF00D, 4'hF);
    read_chk(1, 16'd7, 32'hCAFEF00D);

    // reset in the cycle after an accepted m1 read
    m1_read = 1; m1_address = 16'h0010; m1_byteenable = 4'hF;
    @(negedge clk); chk1("t5_acc", m1_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0; clr();
    repeat (3) begin
      @(negedge clk);
      chk1("t5_m1_rdv_dropped", m1_readdatavalid, 1'b0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    m0_write = 1; m0_address = 16'h40; m0_writedata = 32'h1; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 16'h41; m1_writedata = 32'h2; m1_byteenable = 4'hF;
    @(negedge clk);
    chk1("t5_tie_m0", m0_waitrequest, 1'b0);
    chk1("t5_tie_m1", m1_waitrequest, 1'b1);
    tick();
    m0_write = 0;
    @(negedge clk); chk1("t5_m1_next", m1_waitrequest, 1'b0);
    tick(); clr();
    tick();

    // sustained read contention, then m0 dropping out early
    single(1, 1'b0, 16'd0, 32'h0, 4'hF); tick();
    contend(1'b0, 8, 4);
`ifdef ARB_HOLD_EN
    chk_seq("t6_grants", "000011110000");
`else
    chk_seq("t6_grants", "010101010000");
`endif
    single(1, 1'b0, 16'd0, 32'h0, 4'hF); tick();
    contend(1'b0, 2, 4);
`ifdef ARB_HOLD_EN
    chk_seq("t6_drop", "001111");
`else
    chk_seq("t6_drop", "010111");
`endif
    repeat (3) tick();

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
